// File: rtl/pe_ucore_pkg.sv
// Purpose: shared types and config-field layout for the PE micro-core.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package pe_ucore_pkg;

    typedef enum logic [3:0] {
        OP_PASS    = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_AND     = 4'd3,
        OP_OR      = 4'd4,
        OP_XOR     = 4'd5,
        OP_SHL     = 4'd6,
        OP_SHR     = 4'd7,
        OP_LT      = 4'd8,
        OP_EQ      = 4'd9,
        OP_STEER_T = 4'd10,
        OP_STEER_F = 4'd11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Config register layout, LSB first: opcode, in_mask, target.
    localparam int CFG_OP_LSB   = 0;
    localparam int CFG_OP_W     = 4;
    localparam int CFG_MASK_LSB = CFG_OP_LSB + CFG_OP_W;

    // Default geometry, used by the packed view below.
    localparam int DEF_NUM_IN    = 3;
    localparam int DEF_CNT_WIDTH = 16;

    function automatic int cfg_target_lsb(input int num_in);
        return CFG_MASK_LSB + num_in;
    endfunction

    function automatic int cfg_width(input int num_in, input int cnt_width);
        return CFG_MASK_LSB + num_in + cnt_width;
    endfunction

    // Packed view of the config register for the default geometry.
    typedef struct packed {
        logic [DEF_CNT_WIDTH-1:0] target;
        logic [DEF_NUM_IN-1:0]    in_mask;
        logic [CFG_OP_W-1:0]      opcode;
    } cfg_t;

endpackage

// File: rtl/pe_in_fifo.sv
// Purpose: small circular input buffer for one NoC channel.
// Latency: a word pushed in cycle t is at the head in t+1.
// Backpressure: full is exported so the channel ready can be !full; a push while full is dropped.
// Ports: clr empties the buffer synchronously (a push in the same cycle is discarded);
//        push/push_dat write, pop advances; head_dat/empty/full describe the current state.
module pe_in_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(BUF_DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic                  do_push, do_pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_dat = mem_q[rd_q[AW-1:0]];
    assign do_push  = push && !full && !clr;
    assign do_pop   = pop && !empty && !clr;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q[AW-1:0]] = push_dat;
                wr_d                = wr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pe_ucore_nch.sv
// Purpose: PE micro-core with NUM_IN buffered NoC inputs, opcode FU with steer modes, NUM_OUT broadcast.
// Latency: result registered in the fire cycle, noc_valid all-ones the next cycle.
// Backpressure: per-input ready = !full; the output slot holds until every destination has taken it.
// Ports: ctrl_en/ctrl_clear/ctrl_done control; noc_ivalid/noc_in/noc_oready inputs;
//        noc_out/noc_valid/noc_ready broadcast output; cfg_en/cfg_in/cfg_out serial config chain.
module pe_ucore_nch
    import pe_ucore_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 3,
    parameter int NUM_OUT    = 2,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_en,
    input  logic                         ctrl_clear,
    output logic                         ctrl_done,
    input  logic [NUM_IN-1:0]            noc_ivalid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] noc_in,
    output logic [NUM_IN-1:0]            noc_oready,
    output logic [DATA_WIDTH-1:0]        noc_out,
    output logic [NUM_OUT-1:0]           noc_valid,
    input  logic [NUM_OUT-1:0]           noc_ready,
    input  logic                         cfg_en,
    input  logic                         cfg_in,
    output logic                         cfg_out
);

    localparam int CFG_W   = cfg_width(NUM_IN, CNT_WIDTH);
    localparam int TGT_LSB = cfg_target_lsb(NUM_IN);
    localparam int SH_W    = $clog2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_OUT-1:0]    vld_q, vld_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  done_q, done_d;

    logic [3:0]            op_raw;
    logic [NUM_IN-1:0]     in_mask;
    logic [CNT_WIDTH-1:0]  target;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  hit_target;

    logic [DATA_WIDTH-1:0] head_dat [NUM_IN];
    logic [NUM_IN-1:0]     fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] a, b, res;
    logic                  pred, emit;
    logic [NUM_OUT-1:0]    vld_left;
    logic                  heads_ok, slot_ok, fire;
    logic                  unused_pred_hi;

    assign op_raw  = cfg_q[CFG_OP_LSB +: CFG_OP_W];
    assign in_mask = cfg_q[CFG_MASK_LSB +: NUM_IN];
    assign target  = cfg_q[TGT_LSB +: CNT_WIDTH];

    // Input channels.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        pe_in_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .BUF_DEPTH  (BUF_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (ctrl_clear),
            .push     (fifo_push[i]),
            .push_dat (noc_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop      (fifo_pop[i]),
            .head_dat (head_dat[i]),
            .empty    (fifo_empty[i]),
            .full     (fifo_full[i])
        );
    end

    assign noc_oready = ~fifo_full;
    assign fifo_push  = noc_ivalid & ~fifo_full;
    assign fifo_pop   = {NUM_IN{fire}} & in_mask;

    assign a              = head_dat[0];
    assign b              = head_dat[1];
    assign pred           = head_dat[NUM_IN-1][0];
    assign unused_pred_hi = ^head_dat[NUM_IN-1][DATA_WIDTH-1:1];

    // Functional unit. Unused opcodes fall through to PASS.
    always_comb begin
        res  = a;
        emit = 1'b1;
        case (op_raw)
            OP_ADD:     res = a + b;
            OP_SUB:     res = a - b;
            OP_AND:     res = a & b;
            OP_OR:      res = a | b;
            OP_XOR:     res = a ^ b;
            OP_SHL:     res = a << b[SH_W-1:0];
            OP_SHR:     res = a >> b[SH_W-1:0];
            OP_LT:      res = DATA_WIDTH'(a < b);
            OP_EQ:      res = DATA_WIDTH'(a == b);
            OP_STEER_T: emit = pred;
            OP_STEER_F: emit = ~pred;
            default:    res = a;
        endcase
    end

    // Destinations that still owe a handshake after this cycle; zero means the
    // slot is either empty or drains now, so a new result may load it.
    assign vld_left = vld_q & ~noc_ready;
    assign heads_ok = &(~in_mask | ~fifo_empty);
    assign slot_ok  = (vld_left == '0);
    assign fire     = (state_q == RUN) && ctrl_en && !cfg_en && !ctrl_clear && heads_ok && slot_ok;

    assign cnt_inc    = cnt_q + 1'b1;
    assign hit_target = (target != '0) && (cnt_inc == target);

    always_comb begin
        state_d = state_q;
        if (cfg_en || ctrl_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (ctrl_en) state_d = RUN;
                RUN:     if (fire && hit_target) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_en) begin
            cfg_d = {cfg_in, cfg_q[CFG_W-1:1]};
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        vld_d  = vld_left;
        out_d  = out_q;
        done_d = (state_d == DONE);
        if (ctrl_clear) begin
            cnt_d = '0;
            vld_d = '0;
            out_d = '0;
        end else if (fire) begin
            cnt_d = cnt_inc;
            // A steer with a false predicate is counted but leaves the slot empty.
            if (emit) begin
                vld_d = '1;
                out_d = res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign ctrl_done = done_q;
    assign noc_out   = out_q;
    assign noc_valid = vld_q;
    assign cfg_out   = cfg_q[0];

endmodule

// File: tb/tb_pe_ucore_nch.sv
`timescale 1ns/1ps
module tb_pe_ucore_nch;
    import pe_ucore_pkg::*;

    localparam int DW = 32;
    localparam int NI = 3;
    localparam int NO = 2;
    localparam int NV = 17;

    logic           clk = 1'b0;
    logic           rst_n, ctrl_en, ctrl_clear, ctrl_done;
    logic           cfg_en, cfg_in, cfg_out;
    logic [NI-1:0]  noc_ivalid, noc_oready;
    logic [NI*DW-1:0] noc_in;
    logic [DW-1:0]  noc_out;
    logic [NO-1:0]  noc_valid, noc_ready;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rx_cnt = 0;
    int rx_base;
    int rx_t0[$];
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    cfg_t seen;

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] p;
        logic          emit;
        logic [DW-1:0] res;
    } vec_t;
    vec_t vt [NV];

    pe_ucore_nch #(
        .DATA_WIDTH (DW), .NUM_IN (NI), .NUM_OUT (NO), .BUF_DEPTH (2), .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_en    (ctrl_en),
        .ctrl_clear (ctrl_clear),
        .ctrl_done  (ctrl_done),
        .noc_ivalid (noc_ivalid),
        .noc_in     (noc_in),
        .noc_oready (noc_oready),
        .noc_out    (noc_out),
        .noc_valid  (noc_valid),
        .noc_ready  (noc_ready),
        .cfg_en     (cfg_en),
        .cfg_in     (cfg_in),
        .cfg_out    (cfg_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each destination handshake pops that destination's queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int j = 0; j < NO; j++) begin
                if (noc_valid[j] && noc_ready[j]) begin
                    rx_cnt++;
                    if (j == 0) begin
                        rx_t0.push_back(cyc);
                        if (exp0.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL sb_unexpected_d0: got 0x%0h, expected no output", noc_out);
                        end else chk("sb_d0", noc_out, exp0.pop_front());
                    end else begin
                        if (exp1.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL sb_unexpected_d1: got 0x%0h, expected no output", noc_out);
                        end else chk("sb_d1", noc_out, exp1.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cfg_t mk_cfg(input logic [3:0] op, input logic [2:0] m, input logic [15:0] t);
        return {t, m, op};
    endfunction

    task automatic expect_out(input logic [DW-1:0] v);
        exp0.push_back(v);
        exp1.push_back(v);
    endtask

    // Shifts c in LSB first; returns the bits that came out on cfg_out.
    task automatic shift_cfg(input cfg_t c, output cfg_t old);
        for (int i = 0; i < $bits(cfg_t); i++) begin
            old[i] = cfg_out;
            cfg_in = c[i];
            cfg_en = 1'b1;
            step();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic pulse_clear();
        ctrl_clear = 1'b1;
        step();
        ctrl_clear = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && k < 40) begin
            step();
            k++;
        end
        chk(name, 64'(exp0.size() + exp1.size()), 64'd0);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (ctrl_done !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        chk(name, 64'(ctrl_done), 64'd1);
    endtask

    initial begin
        vt[0]  = '{4'd0,  32'h1234,     32'd5,      32'd0, 1'b1, 32'h1234};
        vt[1]  = '{4'd1,  32'hFFFFFFFF, 32'd2,      32'd0, 1'b1, 32'd1};
        vt[2]  = '{4'd2,  32'd3,        32'd5,      32'd0, 1'b1, 32'hFFFFFFFE};
        vt[3]  = '{4'd3,  32'hF0F0,     32'hFF00,   32'd0, 1'b1, 32'hF000};
        vt[4]  = '{4'd4,  32'hF0F0,     32'h0F00,   32'd0, 1'b1, 32'hFFF0};
        vt[5]  = '{4'd5,  32'hFF00,     32'h0FF0,   32'd0, 1'b1, 32'hF0F0};
        vt[6]  = '{4'd6,  32'd1,        32'h24,     32'd0, 1'b1, 32'h10};
        vt[7]  = '{4'd7,  32'h80000000, 32'd31,     32'd0, 1'b1, 32'd1};
        vt[8]  = '{4'd8,  32'd3,        32'd5,      32'd0, 1'b1, 32'd1};
        vt[9]  = '{4'd8,  32'hFFFFFFFF, 32'd1,      32'd0, 1'b1, 32'd0};
        vt[10] = '{4'd9,  32'd7,        32'd7,      32'd0, 1'b1, 32'd1};
        vt[11] = '{4'd9,  32'd7,        32'd8,      32'd0, 1'b1, 32'd0};
        vt[12] = '{4'd10, 32'd9,        32'd0,      32'd1, 1'b1, 32'd9};
        vt[13] = '{4'd10, 32'd9,        32'd0,      32'd2, 1'b0, 32'd0};
        vt[14] = '{4'd11, 32'h55,       32'd0,      32'd0, 1'b1, 32'h55};
        vt[15] = '{4'd11, 32'h55,       32'd0,      32'd1, 1'b0, 32'd0};
        vt[16] = '{4'd13, 32'hABC,      32'd1,      32'd0, 1'b1, 32'hABC};

        rst_n = 1'b0; ctrl_en = 1'b0; ctrl_clear = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
        noc_ivalid = '0; noc_in = '0; noc_ready = 2'b11;
        repeat (3) step();
        chk("rst_valid", 64'(noc_valid), 64'd0);
        chk("rst_out", 64'(noc_out), 64'd0);
        chk("rst_done", 64'(ctrl_done), 64'd0);
        chk("rst_cfg_out", 64'(cfg_out), 64'd0);
        rst_n = 1'b1;
        step();

        // Opcode table, all three channels masked, target 0.
        ctrl_en = 1'b1;
        for (int v = 0; v < NV; v++) begin
            shift_cfg(mk_cfg(vt[v].op, 3'b111, 16'd0), seen);
            noc_ivalid = 3'b111;
            noc_in = {vt[v].p, vt[v].b, vt[v].a};
            if (vt[v].emit) expect_out(vt[v].res);
            step();
            noc_ivalid = '0;
            repeat (3) step();
            drain($sformatf("vec%0d_drain", v));
            chk($sformatf("vec%0d_consumed", v), 64'(noc_oready), 64'h7);
        end
        chk("target0_never_done", 64'(ctrl_done), 64'd0);

        // Config shift and replay through cfg_out.
        shift_cfg(mk_cfg(4'd1, 3'b011, 16'd3), seen);
        shift_cfg(mk_cfg(4'd1, 3'b011, 16'd3), seen);
        chk("cfg_replay", 64'(seen), 64'(mk_cfg(4'd1, 3'b011, 16'd3)));
        chk("cfg_opcode", 64'(seen.opcode), 64'd1);
        chk("cfg_mask", 64'(seen.in_mask), 64'd3);
        chk("cfg_target", 64'(seen.target), 64'd3);

        // ADD streaming, target 3.
        pulse_clear();
        chk("add_done_init", 64'(ctrl_done), 64'd0);
        rx_t0.delete();
        noc_ivalid = 3'b011; noc_in = {32'd0, 32'd10, 32'd5}; expect_out(32'd15); step();
        noc_in = {32'd0, 32'd1, 32'd7}; expect_out(32'd8); step();
        noc_in = {32'd0, 32'd2, 32'hFFFFFFFF}; expect_out(32'd1); step();
        noc_ivalid = '0;
        wait_done("add_done");
        drain("add_drain");
        chk("add_rx_n", 64'(rx_t0.size()), 64'd3);
        if (rx_t0.size() == 3) begin
            chk("add_b2b_1", 64'(rx_t0[1] - rx_t0[0]), 64'd1);
            chk("add_b2b_2", 64'(rx_t0[2] - rx_t0[1]), 64'd1);
        end
        rx_base = rx_cnt;
        noc_ivalid = 3'b011; noc_in = {32'd0, 32'd1, 32'd1}; step();
        noc_ivalid = '0;
        repeat (4) step();
        chk("done_no_fire", 64'(rx_cnt - rx_base), 64'd0);
        chk("done_hold", 64'(ctrl_done), 64'd1);

        // Broadcast backpressure, PASS on ch0.
        shift_cfg(mk_cfg(4'd0, 3'b001, 16'd0), seen);
        pulse_clear();
        step();
        noc_ready = 2'b01;
        noc_ivalid = 3'b001; noc_in = {64'd0, 32'hA1}; expect_out(32'hA1); step();
        noc_in = {64'd0, 32'hA2}; expect_out(32'hA2); step();
        noc_ivalid = '0;
        @(negedge clk); chk("bp_v1", 64'(noc_valid), 64'd3);
        step(); @(negedge clk); chk("bp_v2", 64'(noc_valid), 64'd2);
        step(); @(negedge clk); chk("bp_v3", 64'(noc_valid), 64'd2);
        step(); noc_ready = 2'b11; @(negedge clk); chk("bp_v4", 64'(noc_valid), 64'd2);
        step(); @(negedge clk);
        chk("bp_reload_v", 64'(noc_valid), 64'd3);
        chk("bp_reload_d", 64'(noc_out), 64'hA2);
        drain("bp_drain");

        // STEER_T with predicate on ch2, target 2.
        shift_cfg(mk_cfg(4'd10, 3'b101, 16'd2), seen);
        pulse_clear();
        rx_base = rx_cnt;
        noc_ivalid = 3'b101; noc_in = {32'd1, 32'd0, 32'd9}; expect_out(32'd9); step();
        noc_in = {32'd0, 32'd0, 32'd4}; step();
        noc_ivalid = '0;
        wait_done("steer_done");
        drain("steer_drain");
        chk("steer_rx", 64'(rx_cnt - rx_base), 64'd2);
        chk("steer_consumed", 64'(noc_oready), 64'h7);

        // FIFO full with firing stalled.
        ctrl_en = 1'b0;
        shift_cfg(mk_cfg(4'd0, 3'b001, 16'd0), seen);
        pulse_clear();
        rx_base = rx_cnt;
        noc_ivalid = 3'b001; noc_in = {64'd0, 32'hB1}; step();
        chk("full_one", 64'(noc_oready[0]), 64'd1);
        noc_in = {64'd0, 32'hB2}; step();
        chk("full_two", 64'(noc_oready[0]), 64'd0);
        noc_in = {64'd0, 32'hB3}; step(); step();
        chk("full_hold", 64'(noc_oready[0]), 64'd0);
        noc_ivalid = '0;
        expect_out(32'hB1); expect_out(32'hB2);
        ctrl_en = 1'b1;
        drain("full_drain");
        repeat (3) step();
        chk("full_rx", 64'(rx_cnt - rx_base), 64'd4);
        chk("full_empty", 64'(noc_oready), 64'h7);

        // Async reset with an output pending.
        pulse_clear();
        noc_ready = 2'b00;
        noc_ivalid = 3'b001; noc_in = {64'd0, 32'h77}; step();
        noc_ivalid = '0;
        step(); step();
        @(negedge clk); chk("rst_pending", 64'(noc_valid), 64'd3);
        #2; rst_n = 1'b0; ctrl_en = 1'b0;
        #1;
        chk("arst_valid", 64'(noc_valid), 64'd0);
        chk("arst_out", 64'(noc_out), 64'd0);
        chk("arst_cfg_out", 64'(cfg_out), 64'd0);
        exp0.delete(); exp1.delete();
        noc_ready = 2'b11;
        step(); step();
        rst_n = 1'b1;
        step();

        // ctrl_clear mid-run keeps config, empties FIFOs, zeroes count.
        shift_cfg(mk_cfg(4'd1, 3'b011, 16'd2), seen);
        ctrl_en = 1'b1;
        noc_ready = 2'b00;
        noc_ivalid = 3'b011; noc_in = {32'd0, 32'd1, 32'd1}; step();
        noc_ivalid = '0;
        step(); step();
        @(negedge clk); chk("clr_pending", 64'(noc_valid), 64'd3);
        step();
        noc_ivalid = 3'b001; noc_in = {64'd0, 32'hC1}; step(); step();
        noc_ivalid = '0;
        chk("clr_full", 64'(noc_oready[0]), 64'd0);
        pulse_clear();
        @(negedge clk);
        chk("clr_valid", 64'(noc_valid), 64'd0);
        chk("clr_fifos", 64'(noc_oready), 64'h7);
        chk("clr_cfg_kept", 64'(cfg_out), 64'd1);
        step();
        noc_ready = 2'b11;
        rx_base = rx_cnt;
        noc_ivalid = 3'b011; noc_in = {32'd0, 32'd4, 32'd3}; expect_out(32'd7); step();
        noc_in = {32'd0, 32'd6, 32'd5}; expect_out(32'd11); step();
        noc_ivalid = '0;
        wait_done("clr_done");
        drain("clr_drain");
        chk("clr_rx", 64'(rx_cnt - rx_base), 64'd4);

        repeat (3) step();
        chk("sb_empty", 64'(exp0.size() + exp1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_ucore_nch.md
Name: pe_ucore_nch

Overview:
- Parametrised successor to the RipTide PE μcore.
- Adds N buffered NoC input channels and an M-way broadcast output with per-destination handshakes.
- Adds a serial daisy-chained config register, an opcode-selected functional unit with steer (predicated) modes, and a fire counter that raises ctrl_done.
- Sits between NoC router ports and the PE's neighbours in the fabric.

Parameters:
- DATA_WIDTH, 32, datapath width.
- NUM_IN, 3, input channels; channel NUM_IN-1 doubles as the predicate.
- NUM_OUT, 2, broadcast output destinations.
- BUF_DEPTH, 2, entries per input FIFO; power of two, ≥2.
- CNT_WIDTH, 16, fire counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_en  in  1  allow firing.
- ctrl_clear  in  1  synchronous clear of FIFOs, counter, output slot and state; config is kept.
- ctrl_done  out  1  target fire count reached.
- noc_ivalid  in  NUM_IN  per-channel input valid.
- noc_in  in  NUM_IN*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- noc_oready  out  NUM_IN  per-channel ready; equals !fifo_full[i].
- noc_out  out  DATA_WIDTH  output data, shared by all destinations.
- noc_valid  out  NUM_OUT  per-destination output valid.
- noc_ready  in  NUM_OUT  per-destination ready.
- cfg_en  in  1  shift config one bit.
- cfg_in  in  1  serial config in.
- cfg_out  out  1  serial config out; equals cfg_reg[0].

Behaviour:
- Reset (rst_n low, async): all outputs 0, all FIFOs empty, cfg_reg = 0, counter = 0, state = IDLE.
- Config:
  - When cfg_en is high: cfg_reg <= {cfg_in, cfg_reg[CFG_W-1:1]}, with CFG_W = 4+NUM_IN+CNT_WIDTH.
  - Fields: [3:0] opcode; [4 +: NUM_IN] in_mask; [4+NUM_IN +: CNT_WIDTH] target.
  - cfg_en forces state to IDLE and blocks firing; it has priority over ctrl_en.
- Opcodes (A = ch0 head, B = ch1 head):
  - 0 PASS A; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
  - 6 SHL A by B[log2(DATA_WIDTH)-1:0]; 7 SHR (logical), same shift amount.
  - 8 LT unsigned, result 1/0; 9 EQ, result 1/0.
  - 10 STEER_T: emit A when pred[0] = 1; 11 STEER_F: emit A when pred[0] = 0.
  - 12-15 behave as PASS.
  - Arithmetic wraps modulo 2^DATA_WIDTH.
- FIFOs:
  - A push occurs when ivalid & oready.
  - A word pushed in cycle t is visible at the head in t+1.
  - Push and pop in the same cycle on a full FIFO is not allowed, because oready = !full.
- States:
  - IDLE -> RUN when ctrl_en & !cfg_en.
  - RUN -> DONE when a fire makes count == target.
  - DONE -> IDLE on ctrl_clear.
  - RUN -> IDLE on ctrl_clear or cfg_en.
  - target = 0 never completes.
- Fire condition (RUN & ctrl_en): every channel with in_mask[i] = 1 is non-empty, and the output slot is free or drains this cycle.
  - Firing pops all masked heads and increments count.
  - Channels with in_mask[i] = 0 are never popped.
- Output:
  - The result registers in the fire cycle; noc_valid = all 1s from the next cycle (latency 1).
  - A destination j completes when noc_valid[j] & noc_ready[j]; its noc_valid[j] drops the following cycle.
  - The slot frees once all NUM_OUT destinations have completed; a back-to-back fire may reload it in that same cycle.
  - Steer with a false predicate consumes the inputs and counts the fire, but produces no output.
- ctrl_done is registered; it is 1 while in DONE.
- ctrl_clear in DONE/RUN drops pending noc_valid and empties the FIFOs in the next cycle.
- ctrl_en low stalls firing only; FIFOs still accept and the output slot still drains.

Decomposition:
- Package pe_ucore_pkg:
  - opcode_e enum (OP_PASS..OP_STEER_F);
  - state_e {IDLE, RUN, DONE};
  - CFG field offset constants;
  - cfg_t packed struct.
- Sub-module pe_in_fifo (DATA_WIDTH, BUF_DEPTH), instantiated NUM_IN times.

Test Plan:
- Config shift: shift 4+3+16 = 23 bits encoding opcode = 1, in_mask = 3'b011, target = 3 -> cfg_reg fields decode to those values; cfg_out replays the earlier bits 23 cycles later.
- ADD streaming: A = {5, 7, 0xFFFFFFFF}, B = {10, 1, 2}, all destinations ready -> noc_out 15, 8, 1 on consecutive cycles; ctrl_done = 1 after the third fire.
- Broadcast backpressure: noc_ready = 2'b01 for 3 cycles then 2'b11 -> noc_valid[0] drops after 1 cycle, noc_valid[1] holds 4 cycles, and the next fire stalls until both have completed.
- STEER_T: A = {9, 4}, pred = {1, 0}, mask = 3'b101 -> a single output 9, count = 2.
- FIFO full: BUF_DEPTH = 2, ctrl_en = 0, push 3 words on ch0 -> noc_oready[0] = 0 after 2 pushes; after ctrl_en = 1, the first two words are processed in order.
- Reset/clear mid-run: assert rst_n = 0 with an output pending -> noc_valid = 0 immediately; separately, ctrl_clear -> FIFOs empty, count = 0, config retained.
